// File: rtl/issue_queue.sv
`default_nettype none
// issue_queue: circular fetch-to-issue queue that takes up to two entries per cycle
// and presents the two oldest entries as an in-order issue pair.
module issue_queue #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 13,
    parameter int INST_W = 32
) (
    input  logic                       CLK,
    input  logic                       NRST,
    input  logic                       f_valid1,
    input  logic                       f_valid2,
    input  logic [PC_W-1:0]            f_pc1,
    input  logic [PC_W-1:0]            f_pc2,
    input  logic [INST_W-1:0]          f_inst1,
    input  logic [INST_W-1:0]          f_inst2,
    output logic                       f_ready,
    output logic                       iss_valid1,
    output logic                       iss_valid2,
    output logic [PC_W-1:0]            iss_pc1,
    output logic [PC_W-1:0]            iss_pc2,
    output logic [INST_W-1:0]          iss_inst1,
    output logic [INST_W-1:0]          iss_inst2,
    input  logic [1:0]                 iss_consume,
    input  logic                       stall,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          ovf_q,    ovf_d;

    logic [1:0]    enq_req;
    logic [1:0]    enq_n;
    logic [1:0]    cons;
    logic [1:0]    deq_n;
    logic [AW-1:0] rd_ptr2;
    logic [AW-1:0] wr_ptr2;

    always_comb begin
        f_ready  = (count_q <= CW'(DEPTH - 2));
        enq_req  = {1'b0, f_valid1} + {1'b0, f_valid1 & f_valid2};
        enq_n    = f_ready ? enq_req : 2'd0;
        cons     = (iss_consume == 2'd3) ? 2'd2 : iss_consume;
        // Retire never exceeds what is actually present.
        if (stall)
            deq_n = 2'd0;
        else if (CW'(cons) > count_q)
            deq_n = count_q[1:0];
        else
            deq_n = cons;
        rd_ptr2  = rd_ptr_q + AW'(1);
        wr_ptr2  = wr_ptr_q + AW'(1);

        rd_ptr_d = rd_ptr_q + AW'(deq_n);
        wr_ptr_d = wr_ptr_q + AW'(enq_n);
        count_d  = count_q + CW'(enq_n) - CW'(deq_n);
        ovf_d    = ovf_q | (~flush & (enq_req != 2'd0) & ~f_ready);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge CLK) begin
        if (!flush && enq_n != 2'd0) begin
            pc_q[wr_ptr_q]   <= f_pc1;
            inst_q[wr_ptr_q] <= f_inst1;
            if (enq_n == 2'd2) begin
                pc_q[wr_ptr2]   <= f_pc2;
                inst_q[wr_ptr2] <= f_inst2;
            end
        end
    end

    always_comb begin
        iss_valid1 = (count_q != '0);
        iss_valid2 = (count_q >= CW'(2));
        iss_pc1    = iss_valid1 ? pc_q[rd_ptr_q]   : '0;
        iss_inst1  = iss_valid1 ? inst_q[rd_ptr_q] : '0;
        iss_pc2    = iss_valid2 ? pc_q[rd_ptr2]    : '0;
        iss_inst2  = iss_valid2 ? inst_q[rd_ptr2]  : '0;
        count      = count_q;
        ovf_err    = ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// tb_issue_queue: directed checks of the issue queue plus a wrap-around scoreboard run.
module tb_issue_queue;

    logic        CLK = 1'b0;
    logic        NRST;
    logic        f_valid1, f_valid2;
    logic [12:0] f_pc1, f_pc2;
    logic [31:0] f_inst1, f_inst2;
    logic        f_ready;
    logic        iss_valid1, iss_valid2;
    logic [12:0] iss_pc1, iss_pc2;
    logic [31:0] iss_inst1, iss_inst2;
    logic [1:0]  iss_consume;
    logic        stall, flush;
    logic [3:0]  count;
    logic        ovf_err;

    int n_pass  = 0;
    int n_check = 0;

    issue_queue #(.DEPTH(8), .PC_W(13), .INST_W(32)) dut (
        .CLK(CLK), .NRST(NRST),
        .f_valid1(f_valid1), .f_valid2(f_valid2),
        .f_pc1(f_pc1), .f_pc2(f_pc2), .f_inst1(f_inst1), .f_inst2(f_inst2),
        .f_ready(f_ready),
        .iss_valid1(iss_valid1), .iss_valid2(iss_valid2),
        .iss_pc1(iss_pc1), .iss_pc2(iss_pc2),
        .iss_inst1(iss_inst1), .iss_inst2(iss_inst2),
        .iss_consume(iss_consume), .stall(stall), .flush(flush),
        .count(count), .ovf_err(ovf_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mk_inst(input logic [12:0] pc);
        return {19'h600, pc};
    endfunction

    task automatic drive(input logic v1, input logic v2, input logic [12:0] p1,
                         input logic [12:0] p2, input logic [1:0] cons,
                         input logic st, input logic fl);
        f_valid1 = v1; f_valid2 = v2;
        f_pc1 = p1; f_pc2 = p2;
        f_inst1 = mk_inst(p1); f_inst2 = mk_inst(p2);
        iss_consume = cons; stall = st; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 13'h0, 13'h0, 2'd0, 1'b0, 1'b0);
    endtask

    logic [12:0] exp_q[$];
    int          pairs_sent;
    int          issued;
    int          ret;
    int          cyc;
    logic [1:0]  rc;

    initial begin
        NRST = 1'b0;
        idle();
        #12;
        check("rst_count",  count, 0);
        check("rst_valid1", iss_valid1, 0);
        check("rst_valid2", iss_valid2, 0);
        check("rst_pc1",    iss_pc1, 0);
        check("rst_inst1",  iss_inst1, 0);
        check("rst_ready",  f_ready, 1);
        check("rst_ovf",    ovf_err, 0);
        @(negedge CLK);
        NRST = 1'b1;
        tick();

        // Test 1: first pair, no bypass before the edge
        drive(1'b1, 1'b1, 13'h10, 13'h14, 2'd0, 1'b0, 1'b0);
        #1;
        check("t1_nobypass", iss_valid1, 0);
        tick();
        check("t1_valid1", iss_valid1, 1);
        check("t1_valid2", iss_valid2, 1);
        check("t1_pc1",    iss_pc1, 13'h10);
        check("t1_pc2",    iss_pc2, 13'h14);
        check("t1_inst2",  iss_inst2, mk_inst(13'h14));
        check("t1_count",  count, 2);

        // Test 2: dependency hold then dual retire
        drive(1'b1, 1'b1, 13'h18, 13'h1C, 2'd0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b1, 13'h20, 13'h24, 2'd0, 1'b0, 1'b0); tick();
        check("t2_count6", count, 6);
        drive(1'b0, 1'b0, 13'h0, 13'h0, 2'd1, 1'b0, 1'b0); tick();
        check("t2_pc1_c1", iss_pc1, 13'h14);
        check("t2_pc2_c1", iss_pc2, 13'h18);
        check("t2_count5", count, 5);
        drive(1'b0, 1'b0, 13'h0, 13'h0, 2'd2, 1'b0, 1'b0); tick();
        check("t2_count3", count, 3);
        check("t2_pc1_c2", iss_pc1, 13'h1C);
        check("t2_pc2_c2", iss_pc2, 13'h20);

        // Test 3: fill to 7 (wraps index 7->0), overflow with simultaneous retire
        drive(1'b1, 1'b1, 13'h28, 13'h2C, 2'd0, 1'b0, 1'b0); tick();
        check("t3_count5", count, 5);
        check("t3_ready5", f_ready, 1);
        drive(1'b1, 1'b1, 13'h30, 13'h34, 2'd0, 1'b0, 1'b0); tick();
        check("t3_count7", count, 7);
        check("t3_ready7", f_ready, 0);
        check("t3_ovf0",   ovf_err, 0);
        drive(1'b1, 1'b1, 13'h38, 13'h3C, 2'd2, 1'b0, 1'b0); tick();
        check("t3_count_ovf", count, 5);
        check("t3_ovf1",      ovf_err, 1);
        check("t3_ready_ovf", f_ready, 1);
        check("t3_pc1_ovf",   iss_pc1, 13'h24);
        check("t3_pc2_ovf",   iss_pc2, 13'h28);
        idle(); tick();
        check("t3_ovf_sticky", ovf_err, 1);
        drive(1'b0, 1'b0, 13'h0, 13'h0, 2'd2, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 13'h0, 13'h0, 2'd2, 1'b0, 1'b0); tick();
        check("t3_wrap_pc1",   iss_pc1, 13'h34);
        check("t3_wrap_inst1", iss_inst1, mk_inst(13'h34));
        check("t3_wrap_cnt",   count, 1);
        drive(1'b1, 1'b1, 13'h38, 13'h3C, 2'd0, 1'b0, 1'b0); tick();

        // Test 4: flush beats stall, retire and enqueue
        drive(1'b1, 1'b1, 13'h40, 13'h44, 2'd2, 1'b1, 1'b1); tick();
        check("t4_count",  count, 0);
        check("t4_valid1", iss_valid1, 0);
        check("t4_inst1",  iss_inst1, 0);
        check("t4_ovf",    ovf_err, 1);
        drive(1'b0, 1'b1, 13'h4C, 13'h4C, 2'd0, 1'b0, 1'b0); tick();
        check("t4_v2_only", count, 0);
        drive(1'b1, 1'b0, 13'h50, 13'h54, 2'd0, 1'b0, 1'b0); tick();
        check("t4_count1", count, 1);
        check("t4_pc1",    iss_pc1, 13'h50);
        check("t4_valid2", iss_valid2, 0);
        check("t4_pc2",    iss_pc2, 0);

        // Test 5: stall blocks retire but enqueue proceeds
        drive(1'b1, 1'b1, 13'h58, 13'h5C, 2'd2, 1'b1, 1'b0); tick();
        check("t5_count", count, 3);
        check("t5_pc1",   iss_pc1, 13'h50);
        check("t5_pc2",   iss_pc2, 13'h58);
        drive(1'b0, 1'b0, 13'h0, 13'h0, 2'd3, 1'b0, 1'b0); tick();
        check("t5_cons3_cnt", count, 1);
        check("t5_cons3_pc1", iss_pc1, 13'h5C);
        drive(1'b0, 1'b0, 13'h0, 13'h0, 2'd2, 1'b0, 1'b0); tick();
        check("t5_nounder_cnt", count, 0);
        check("t5_nounder_v1",  iss_valid1, 0);

        // Test 6: scoreboard run across wrap with random retire
        exp_q.delete();
        pairs_sent = 0;
        issued = 0;
        cyc = 0;
        while ((pairs_sent < 20 || exp_q.size() != 0) && cyc < 300) begin
            rc = 2'($urandom_range(0, 2));
            if (pairs_sent < 20 && exp_q.size() <= 6)
                drive(1'b1, 1'b1, 13'(13'h100 + 8 * pairs_sent), 13'(13'h104 + 8 * pairs_sent),
                      rc, 1'b0, 1'b0);
            else
                drive(1'b0, 1'b0, 13'h0, 13'h0, rc, 1'b0, 1'b0);
            #1;
            check("t6_count", count, 64'(exp_q.size()));
            check("t6_ready", f_ready, 64'(exp_q.size() <= 6));
            if (exp_q.size() >= 1) begin
                check("t6_pc1",   iss_pc1, exp_q[0]);
                check("t6_inst1", iss_inst1, mk_inst(exp_q[0]));
            end else
                check("t6_valid1", iss_valid1, 0);
            if (exp_q.size() >= 2)
                check("t6_pc2", iss_pc2, exp_q[1]);
            ret = (int'(rc) < exp_q.size()) ? int'(rc) : exp_q.size();
            for (int k = 0; k < ret; k++) begin
                void'(exp_q.pop_front());
                issued++;
            end
            if (f_valid1) begin
                exp_q.push_back(f_pc1);
                exp_q.push_back(f_pc2);
                pairs_sent++;
            end
            tick();
            cyc++;
        end
        check("t6_issued", issued, 40);
        check("t6_empty",  count, 0);

        // Asynchronous reset mid-operation clears without a clock edge
        drive(1'b1, 1'b1, 13'h70, 13'h74, 2'd0, 1'b0, 1'b0); tick();
        idle();
        drive(1'b1, 1'b1, 13'h78, 13'h7C, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
        check("t7_pre_count", count, 4);
        #2;
        NRST = 1'b0;
        #1;
        check("t7_count",  count, 0);
        check("t7_valid1", iss_valid1, 0);
        check("t7_ready",  f_ready, 1);
        #3;
        NRST = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
